// File: rtl/csoc_test_pkg.sv
// Shared state encoding and ASCII constants for the CSOC scan controller.
// LOAD states exist only when CSOC_SCAN_LOAD_EN is defined.
package csoc_test_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RST,
    CAPTURE,
    TX_REQ,
    TX_WAIT,
    SHIFT_CLK,
    RUN_CLK,
    NEWLINE,
    ACK,
    ACK_NL,
    ERR
`ifdef CSOC_SCAN_LOAD_EN
    ,
    LOAD_RX,
    LOAD_CLK
`endif
  } state_t;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_1     = 8'h31;
  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_K     = 8'h4B;
  localparam logic [7:0] CH_Q     = 8'h3F;
  localparam logic [7:0] CMD_RST  = 8'h72;
  localparam logic [7:0] CMD_DUMP = 8'h64;
  localparam logic [7:0] CMD_RUN  = 8'h63;
  localparam logic [7:0] CMD_LOAD = 8'h6C;

  function automatic logic [7:0] bit_char(input logic b);
    return b ? CH_1 : CH_0;
  endfunction

endpackage

// File: rtl/csoc_clk_gen.sv
// Single csoc_clk pulse generator: CLK_DIV clks low, CLK_DIV clks high, then low.
// Latency 2*CLK_DIV clks from request to pulse_done_o; requests while active are ignored.
module csoc_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_req_i,
  output logic csoc_clk_o,
  output logic pulse_done_o
);

  localparam int PW = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

  logic          active_q, active_d;
  logic          clk_q, clk_d;
  logic          done_q, done_d;
  logic [PW-1:0] ph_q, ph_d;

  always_comb begin
    active_d = active_q;
    clk_d    = clk_q;
    done_d   = 1'b0;
    ph_d     = ph_q;
    if (!active_q) begin
      if (pulse_req_i) begin
        active_d = 1'b1;
        ph_d     = '0;
      end
    end else if (ph_q == PH_LAST) begin
      ph_d = '0;
      if (!clk_q) begin
        clk_d = 1'b1;
      end else begin
        clk_d    = 1'b0;
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end else begin
      ph_d = ph_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      clk_q    <= 1'b0;
      done_q   <= 1'b0;
      ph_q     <= '0;
    end else begin
      active_q <= active_d;
      clk_q    <= clk_d;
      done_q   <= done_d;
      ph_q     <= ph_d;
    end
  end

  assign csoc_clk_o   = clk_q;
  assign pulse_done_o = done_q;

endmodule

// File: rtl/csoc_scan_ctrl.sv
// Command-driven CSOC test controller: 'r' reset, 'd' scan dump, 'c' run; 'l' load with CSOC_SCAN_LOAD_EN.
// Commands accepted only in IDLE (others dropped while busy); every TX byte waits on tx_ready.
module csoc_scan_ctrl
  import csoc_test_pkg::*;
#(
  parameter int NREGS      = 1919,
  parameter int NCHAINS    = 1,
  parameter int RUN_CLKS   = 10,
  parameter int MAX_COLS   = 70,
  parameter int CLK_DIV    = 2,
  parameter int RST_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_ready,
  output logic               busy,
  output logic               csoc_clk,
  output logic               csoc_rstn,
  output logic               csoc_test_se,
  output logic               csoc_test_tm,
  input  logic [NCHAINS-1:0] csoc_scan_out,
  output logic [NCHAINS-1:0] csoc_scan_in
);

  localparam int SW = $clog2(NREGS + 1);
  localparam int CW = $clog2(MAX_COLS + 1);
  localparam int NW = $clog2(NCHAINS + 1);
  localparam int UW = $clog2(RUN_CLKS + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  localparam logic [SW-1:0] SHIFT_END  = SW'(NREGS);
  localparam logic [CW-1:0] COL_END    = CW'(MAX_COLS);
  localparam logic [NW-1:0] CHAIN_END  = NW'(NCHAINS);
  localparam logic [NW-1:0] CHAIN_LAST = NW'(NCHAINS - 1);
  localparam logic [UW-1:0] RUN_END    = UW'(RUN_CLKS);
  localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYCLES - 1);

  state_t              state_q, state_d;
  state_t              ret_q, ret_d;
  logic [7:0]          txb_q, txb_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                busy_q, busy_d;
  logic                rstn_q, rstn_d;
  logic                se_q, se_d;
  logic                tm_q;
  logic [NCHAINS-1:0]  scan_in_q, scan_in_d;
  logic [NCHAINS-1:0]  cap_q, cap_d;
  logic [SW-1:0]       shift_q, shift_d;
  logic [CW-1:0]       col_q, col_d;
  logic [NW-1:0]       chain_q, chain_d;
  logic [UW-1:0]       run_q, run_d;
  logic [RW-1:0]       rcnt_q, rcnt_d;
  logic                pend_q, pend_d;

  logic                pulse_req;
  logic                pulse_done;
  logic                chain_bit;

  csoc_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk         (clk),
    .rst         (rst),
    .pulse_req_i (pulse_req),
    .csoc_clk_o  (csoc_clk),
    .pulse_done_o(pulse_done)
  );

  always_comb begin
    chain_bit = 1'b0;
    for (int i = 0; i < NCHAINS; i++) begin
      if (chain_q == NW'(i)) chain_bit = cap_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    txb_d      = txb_q;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    busy_d     = busy_q;
    rstn_d     = rstn_q;
    se_d       = se_q;
    scan_in_d  = scan_in_q;
    cap_d      = cap_q;
    shift_d    = shift_q;
    col_d      = col_q;
    chain_d    = chain_q;
    run_d      = run_q;
    rcnt_d     = rcnt_q;
    pend_d     = pend_q;
    pulse_req  = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          busy_d = 1'b1;
          case (rx_data)
            CMD_RST: begin
              rstn_d  = 1'b0;
              rcnt_d  = '0;
              state_d = RST;
            end
            CMD_DUMP: begin
              se_d    = 1'b1;
              shift_d = '0;
              col_d   = '0;
              state_d = CAPTURE;
            end
            CMD_RUN: begin
              se_d    = 1'b0;
              run_d   = '0;
              pend_d  = 1'b0;
              state_d = RUN_CLK;
            end
`ifdef CSOC_SCAN_LOAD_EN
            CMD_LOAD: begin
              se_d    = 1'b1;
              shift_d = '0;
              chain_d = '0;
              state_d = LOAD_RX;
            end
`endif
            default: state_d = ERR;
          endcase
        end
      end

      RST: begin
        if (rcnt_q == RST_LAST) begin
          rstn_d  = 1'b1;
          state_d = ACK;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end

      CAPTURE: begin
        cap_d   = csoc_scan_out;
        chain_d = '0;
        pend_d  = 1'b0;
        state_d = SHIFT_CLK;
      end

      // Emits this shift's chars (wrapping lazily before a char), then clocks the chain.
      SHIFT_CLK: begin
        if (chain_q != CHAIN_END) begin
          if (col_q == COL_END) begin
            state_d = NEWLINE;
          end else begin
            txb_d   = bit_char(chain_bit);
            col_d   = col_q + CW'(1);
            chain_d = chain_q + NW'(1);
            ret_d   = SHIFT_CLK;
            state_d = TX_REQ;
          end
        end else if (!pend_q) begin
          scan_in_d = cap_q;
          pulse_req = 1'b1;
          pend_d    = 1'b1;
        end else if (pulse_done) begin
          pend_d  = 1'b0;
          shift_d = shift_q + SW'(1);
          state_d = (shift_q + SW'(1) == SHIFT_END) ? NEWLINE : CAPTURE;
        end
      end

      RUN_CLK: begin
        if (run_q == RUN_END) begin
          state_d = ACK;
        end else if (!pend_q) begin
          pulse_req = 1'b1;
          pend_d    = 1'b1;
        end else if (pulse_done) begin
          pend_d = 1'b0;
          run_d  = run_q + UW'(1);
        end
      end

      NEWLINE: begin
        txb_d   = CH_NL;
        col_d   = '0;
        ret_d   = (shift_q == SHIFT_END) ? ACK : SHIFT_CLK;
        state_d = TX_REQ;
      end

      ACK: begin
        txb_d   = CH_K;
        ret_d   = ACK_NL;
        state_d = TX_REQ;
      end

      ACK_NL: begin
        txb_d   = CH_NL;
        ret_d   = IDLE;
        state_d = TX_REQ;
      end

      ERR: begin
        txb_d   = CH_Q;
        ret_d   = ACK_NL;
        state_d = TX_REQ;
      end

      TX_REQ: begin
        if (tx_ready) begin
          tx_data_d  = txb_q;
          tx_start_d = 1'b1;
          state_d    = TX_WAIT;
        end
      end

      // tx_start held until the UART drops ready; byte done when ready returns.
      TX_WAIT: begin
        if (tx_start_q) begin
          if (!tx_ready) tx_start_d = 1'b0;
        end else if (tx_ready) begin
          state_d = ret_q;
          if (ret_q == IDLE) begin
            busy_d = 1'b0;
            se_d   = 1'b0;
          end
        end
      end

`ifdef CSOC_SCAN_LOAD_EN
      LOAD_RX: begin
        if (rx_valid) begin
          if (rx_data == CH_0 || rx_data == CH_1) begin
            for (int i = 0; i < NCHAINS; i++) begin
              if (chain_q == NW'(i)) cap_d[i] = rx_data[0];
            end
            if (chain_q == CHAIN_LAST) begin
              scan_in_d = cap_d;
              pend_d    = 1'b0;
              state_d   = LOAD_CLK;
            end else begin
              chain_d = chain_q + NW'(1);
            end
          end else begin
            se_d    = 1'b0;
            state_d = ERR;
          end
        end
      end

      LOAD_CLK: begin
        if (!pend_q) begin
          pulse_req = 1'b1;
          pend_d    = 1'b1;
        end else if (pulse_done) begin
          pend_d  = 1'b0;
          shift_d = shift_q + SW'(1);
          chain_d = '0;
          state_d = (shift_q + SW'(1) == SHIFT_END) ? ACK : LOAD_RX;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ret_q      <= IDLE;
      txb_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      rstn_q     <= 1'b1;
      se_q       <= 1'b0;
      tm_q       <= 1'b1;
      scan_in_q  <= '0;
      cap_q      <= '0;
      shift_q    <= '0;
      col_q      <= '0;
      chain_q    <= '0;
      run_q      <= '0;
      rcnt_q     <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      txb_q      <= txb_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      rstn_q     <= rstn_d;
      se_q       <= se_d;
      tm_q       <= 1'b1;
      scan_in_q  <= scan_in_d;
      cap_q      <= cap_d;
      shift_q    <= shift_d;
      col_q      <= col_d;
      chain_q    <= chain_d;
      run_q      <= run_d;
      rcnt_q     <= rcnt_d;
      pend_q     <= pend_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign busy         = busy_q;
  assign csoc_rstn    = rstn_q;
  assign csoc_test_se = se_q;
  assign csoc_test_tm = tm_q;
  assign csoc_scan_in = scan_in_q;

endmodule
